mul_multiple_gen: RTL

- Front-end controller for the radix-8 Booth multiplier unit (MulUnit).
- Accepts a signed 8-bit multiplicand and precomputes its magnitude odd multiples 1X/3X/5X/7X with one shared adder over 3 cycles. It then holds those multiples and the sign stable while streaming unsigned 8-bit multiplier bytes into the unit.
- Tracks the unit's fixed pipeline latency and re-times the returned 16-bit products with a valid strobe.

---
 rtl/mul_multiple_gen.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mul_multiple_gen.sv
// Radix-8 Booth front end: computes |mcd| odd multiples (1X/3X/5X/7X) over 3 cycles, streams multiplier bytes, re-times products.
// Latency: multiplicand->READY 3 cycles; multiplier accept->oProdValid MUL_LAT+2 cycles. No product back-pressure. Optional MUL_PRODCNT_EN counter.
module mul_multiple_gen #(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iMcdValid,
    output logic             oMcdReady,
    input  logic [7:0]       iMcd,
    input  logic             iMprValid,
    output logic             oMprReady,
    input  logic [7:0]       iMpr,
    output logic [7:0]       oMulDat,
    output logic [6:0]       oDat1X,
    output logic [8:0]       oDat3X,
    output logic [9:0]       oDat5X,
    output logic [9:0]       oDat7X,
    output logic             oNegative,
    input  logic [15:0]      iProd,
    output logic             oProdValid,
    output logic [15:0]      oProd,
    output logic             oErrClamp,
    output logic [CNT_W-1:0] oProdCnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC3 = 3'd1;
    localparam logic [2:0] S_CALC5 = 3'd2;
    localparam logic [2:0] S_CALC7 = 3'd3;
    localparam logic [2:0] S_READY = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [6:0]       mag_q, mag_d;
    logic [8:0]       x3_q, x3_d;
    logic [9:0]       x5_q, x5_d;
    logic [9:0]       x7_q, x7_d;
    logic             neg_q, neg_d;
    logic             err_q, err_d;
    logic [7:0]       mul_dat_q, mul_dat_d;
    logic [MUL_LAT:0] vld_q, vld_d;
    logic             prod_vld_q;
    logic [15:0]      prod_q, prod_d;

    logic             mcd_rdy, mcd_acc, mpr_rdy, mpr_acc;
    logic             clamp;
    logic [6:0]       ld_mag;
    logic [9:0]       mag_ext, add_a, add_res;

    // Multiplicand may only change once every in-flight product has been delivered
    assign mcd_rdy = ((state_q == S_IDLE) || (state_q == S_READY)) &&
                     (vld_q == '0) && !prod_vld_q;
    assign mcd_acc = iMcdValid && mcd_rdy;
    assign mpr_rdy = (state_q == S_READY) && !mcd_acc;
    assign mpr_acc = iMprValid && mpr_rdy;

    assign clamp  = (iMcd == 8'h80);
    assign ld_mag = clamp   ? 7'h7f :
                    iMcd[7] ? 7'(~iMcd[6:0] + 7'd1) : iMcd[6:0];

    // Single shared adder: shifted magnitude +/- magnitude, selected by state
    assign mag_ext = {3'b000, mag_q};
    always_comb begin
        add_a = mag_ext << 3;
        case (state_q)
            S_CALC3: add_a = mag_ext << 1;
            S_CALC5: add_a = mag_ext << 2;
            default: add_a = mag_ext << 3;
        endcase
    end
    assign add_res = (state_q == S_CALC7) ? (add_a - mag_ext) : (add_a + mag_ext);

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        x3_d      = x3_q;
        x5_d      = x5_q;
        x7_d      = x7_q;
        neg_d     = neg_q;
        err_d     = err_q;
        mul_dat_d = mul_dat_q;
        prod_d    = prod_q;
        vld_d     = {vld_q[MUL_LAT-1:0], mpr_acc};
        case (state_q)
            S_CALC3: begin
                x3_d    = add_res[8:0];
                state_d = S_CALC5;
            end
            S_CALC5: begin
                x5_d    = add_res;
                state_d = S_CALC7;
            end
            S_CALC7: begin
                x7_d    = add_res;
                state_d = S_READY;
            end
            default: ;
        endcase
        if (mcd_acc) begin
            mag_d   = ld_mag;
            neg_d   = iMcd[7];
            err_d   = err_q | clamp;
            state_d = S_CALC3;
        end
        if (mpr_acc) begin
            mul_dat_d = iMpr;
        end
        if (vld_q[MUL_LAT]) begin
            prod_d = iProd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mag_q      <= '0;
            x3_q       <= '0;
            x5_q       <= '0;
            x7_q       <= '0;
            neg_q      <= 1'b0;
            err_q      <= 1'b0;
            mul_dat_q  <= '0;
            vld_q      <= '0;
            prod_vld_q <= 1'b0;
            prod_q     <= '0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            x3_q       <= x3_d;
            x5_q       <= x5_d;
            x7_q       <= x7_d;
            neg_q      <= neg_d;
            err_q      <= err_d;
            mul_dat_q  <= mul_dat_d;
            vld_q      <= vld_d;
            prod_vld_q <= vld_q[MUL_LAT];
            prod_q     <= prod_d;
        end
    end

`ifdef MUL_PRODCNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign cnt_d = prod_vld_q ? (cnt_q + CNT_W'(1)) : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
    assign oProdCnt = cnt_q;
`else
    assign oProdCnt = '0;
`endif

    assign oMcdReady  = mcd_rdy;
    assign oMprReady  = mpr_rdy;
    assign oMulDat    = mul_dat_q;
    assign oDat1X     = mag_q;
    assign oDat3X     = x3_q;
    assign oDat5X     = x5_q;
    assign oDat7X     = x7_q;
    assign oNegative  = neg_q;
    assign oProdValid = prod_vld_q;
    assign oProd      = prod_q;
    assign oErrClamp  = err_q;

endmodule
